port_muldiv: RTL and testbench
==============================

# port_muldiv

Memory-mapped arithmetic coprocessor that sits on the far side of the microcontroller's output and input ports. The CPU writes operands and a command byte to output ports ps0–ps2. The block runs a multi-cycle unsigned multiply or divide, or a single-cycle add, and returns results and status on input ports Pe0, Pe2 and the 3-bit Pe1. It is the consumer of the CPU's port writes and the producer of its port reads.

## Interface

Parameters:
- WIDTH, default 8: operand and result-byte width; also the iteration count for MUL and DIV.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low; low forces IDLE and clears every register.
- op_a  in  WIDTH  operand A; wired to ps0.
- op_b  in  WIDTH  operand B; wired to ps1.
- cmd  in  WIDTH  command byte; wired to ps2.
  - cmd[WIDTH-1] is go.
  - cmd[1:0] is op: 00 MUL, 01 DIV, 10 ADD, 11 reserved.
  - All other bits are ignored.
- res_lo  out  WIDTH  result low byte; wired to Pe0.
- res_hi  out  WIDTH  result high byte; wired to Pe2.
- status  out  3  {err, done, busy}; wired to Pe1.

## Operation

- **Start condition:** a start is a rising edge of go while in IDLE or DONE.
  - go_q is a go sample registered every cycle.
  - A start is detected when go=1 and go_q=0.
  - The CPU must write go=0, then go=1, to issue each command.
- **FSM states:** IDLE, RUN, DONE.
- **Start edge E0:**
  - Latch op_a, op_b and op into internal registers.
  - Clear err and done.
  - Load the iteration counter with WIDTH.
- **ADD, DIV with op_b=0, and reserved op:** go to RUN with counter 1, so they complete at E1.
- **MUL:** unsigned shift-add, one partial product per cycle, LSB of B first.
  - Product is 2·WIDTH bits.
  - res_lo = product[WIDTH-1:0], res_hi = product[2·WIDTH-1:WIDTH].
- **DIV:** unsigned restoring division, one quotient bit per cycle, MSB first.
  - res_lo = quotient, res_hi = remainder.
- **DIV with op_b=0:** err=1, res_lo = all ones, res_hi = latched A.
- **ADD:**
  - res_lo = (A+B) mod 2^WIDTH.
  - res_hi = {0…0, carry}.
- **Reserved op:** err=1, res_lo = 0, res_hi = 0.
- **RUN exit:** when the counter reaches 0, go to DONE.
- **DONE exit:** DONE holds until the next start, which goes directly to RUN.
- **Starts during RUN are ignored.**
  - go_q keeps tracking, so a rise during RUN is not remembered.
  - The command is lost.
- **Operand/cmd changes during RUN:** no effect, because all operands are latched at E0.
- **res_lo/res_hi** hold the previous result through RUN. They update only on the completion edge.

## Timing

- **Reset values:** res_lo=0, res_hi=0, status=3'b000, state IDLE, go_q=0.
- **busy:** 1 from after E0 until the completion edge, inclusive of all RUN cycles.
- **MUL/DIV latency:**
  - Results and done=1 are visible after edge E_WIDTH (E8 for WIDTH=8).
  - busy=0 in the same cycle.
- **ADD, DIV-by-zero, reserved latency:** results, done and err are visible after E1.
- **done and err:** remain set until the next accepted start clears them at E0.
- **go high at reset release:** if go is already 1, go_q=0 after reset, so a start is taken on the first edge.
- **Reset asserted mid-RUN:** immediate return to reset values. No partial result is exposed.
- **Simultaneous start and completion:** impossible, because starts are ignored in RUN.
- **Start edge coinciding with the DONE cycle:** accepted.
- **Combinational paths:** none from inputs to outputs; all outputs are registered.

## Test plan

- **MUL:** A=200 (0xC8), B=150 (0x96), op=00, go 0→1.
  - Status=001 for 8 cycles.
  - Then res_lo=0x30, res_hi=0x75, status=010.
- **DIV:** A=200, B=7, op=01.
  - After 8 cycles: res_lo=0x1C, res_hi=0x04, status=010.
  - Repeat with A=5, B=9: res_lo=0x00, res_hi=0x05.
- **Single-cycle ops:**
  - DIV with B=0, A=0xC8: after 1 cycle, res_lo=0xFF, res_hi=0xC8, status=110.
  - ADD with A=0xF0, B=0x20: after 1 cycle, res_lo=0x10, res_hi=0x01, status=010.
  - Reserved op=11: after 1 cycle, status=110, res_lo=0x00, res_hi=0x00.
- **go handling:**
  - Hold go=1 across two full operation lengths: exactly one operation runs.
  - Toggle go 0→1 in RUN cycle 3 while changing op_a: ignored; the original result is produced.
  - A later 0→1 in DONE starts a new op and clears done at E0.
- **Reset:**
  - Drop reset in MUL RUN cycle 4: outputs read 0 and status reads 000 immediately.
  - After release, a fresh MUL 0xFF×0xFF gives res_lo=0x01, res_hi=0xFE.

Source files
------------

// File: rtl/port_muldiv.sv
// Port-mapped arithmetic coprocessor: sequential unsigned MUL/DIV, single-cycle ADD.
// Operands and command arrive on CPU output ports; results and status return on input ports.
module port_muldiv #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [WIDTH-1:0] cmd,
  output logic [WIDTH-1:0] res_lo,
  output logic [WIDTH-1:0] res_hi,
  output logic [2:0]       status
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [1:0] OP_MUL = 2'b00, OP_DIV = 2'b01, OP_ADD = 2'b10;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;

  logic             go_q, err, done, start, last;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [CW-1:0]    cnt;
  logic [2*WIDTH-1:0] acc;

  // Only go and op are decoded from the command byte.
  logic cmd_unused;
  assign cmd_unused = ^cmd[WIDTH-2:2];

  assign start  = cmd[WIDTH-1] & ~go_q & (state != RUN);
  assign last   = (state == RUN) && (cnt == CW'(1));
  assign status = {err, done, state == RUN};

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: if (start) state_nx = RUN;
      RUN:        if (cnt == CW'(1)) state_nx = DONE;
      default:    state_nx = IDLE;
    endcase
  end

  // MUL: acc = {partial sum, remaining multiplier bits}, shifted right each step.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_nx;
  assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? a_q : {WIDTH{1'b0}})};
  assign mul_nx  = {mul_sum, acc[WIDTH-1:1]};

  // DIV: acc = {remainder, dividend bits / quotient bits}, shifted left each step.
  logic [WIDTH:0]     div_t, div_sub;
  logic               div_ge;
  logic [WIDTH-1:0]   div_r;
  logic [2*WIDTH-1:0] div_nx;
  assign div_t   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign div_sub = div_t - {1'b0, b_q};
  assign div_ge  = div_t >= {1'b0, b_q};
  assign div_r   = div_ge ? div_sub[WIDTH-1:0] : div_t[WIDTH-1:0];
  assign div_nx  = {div_r, acc[WIDTH-2:0], div_ge};

  logic [WIDTH:0]   add_s;
  logic [WIDTH-1:0] fin_lo, fin_hi;
  logic             fin_err;
  assign add_s = {1'b0, a_q} + {1'b0, b_q};

  always_comb begin
    fin_err = 1'b0;
    fin_lo  = '0;
    fin_hi  = '0;
    case (op_q)
      OP_MUL: {fin_hi, fin_lo} = mul_nx;
      OP_DIV:
        if (b_q == '0) begin
          fin_err = 1'b1;
          fin_lo  = '1;
          fin_hi  = a_q;
        end else {fin_hi, fin_lo} = div_nx;
      OP_ADD: begin
        fin_lo = add_s[WIDTH-1:0];
        fin_hi = {{(WIDTH-1){1'b0}}, add_s[WIDTH]};
      end
      default: fin_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      go_q   <= 1'b0;
      err    <= 1'b0;
      done   <= 1'b0;
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      cnt    <= '0;
      acc    <= '0;
      res_lo <= '0;
      res_hi <= '0;
    end else begin
      state <= state_nx;
      go_q  <= cmd[WIDTH-1];
      if (start) begin
        a_q  <= op_a;
        b_q  <= op_b;
        op_q <= cmd[1:0];
        err  <= 1'b0;
        done <= 1'b0;
        cnt  <= (cmd[1:0] == OP_MUL || (cmd[1:0] == OP_DIV && op_b != '0)) ? CW'(WIDTH) : CW'(1);
        acc  <= (cmd[1:0] == OP_MUL) ? {{WIDTH{1'b0}}, op_b} : {{WIDTH{1'b0}}, op_a};
      end else if (state == RUN) begin
        cnt <= cnt - CW'(1);
        acc <= (op_q == OP_MUL) ? mul_nx : div_nx;
        if (last) begin
          res_lo <= fin_lo;
          res_hi <= fin_hi;
          err    <= fin_err;
          done   <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_port_muldiv.sv
// Directed bench for port_muldiv: MUL/DIV/ADD/reserved results, go edge rules, reset.
module tb_port_muldiv;
  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] op_a, op_b, cmd;
  logic [7:0] res_lo, res_hi;
  logic [2:0] status;
  int checks = 0;
  int errors = 0;

  port_muldiv #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .op_a(op_a), .op_b(op_b), .cmd(cmd),
    .res_lo(res_lo), .res_hi(res_hi), .status(status)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); @(negedge clk); end
  endtask

  // Drops go for one cycle, then raises it with the new command; returns just after E0.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
    @(negedge clk); cmd = 8'h00;
    @(negedge clk); op_a = a; op_b = b; cmd = {1'b1, 5'b0, op};
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0; op_a = 8'h01; op_b = 8'h02; cmd = 8'h82;
    #23;
    checks++; if (res_lo !== 8'h00) begin errors++; $display("FAIL rst_lo got %h exp 00", res_lo); end
    checks++; if (res_hi !== 8'h00) begin errors++; $display("FAIL rst_hi got %h exp 00", res_hi); end
    checks++; if (status !== 3'b000) begin errors++; $display("FAIL rst_status got %b exp 000", status); end
    @(negedge clk); reset = 1'b1;
    step(1);
    checks++; if (status !== 3'b001) begin errors++; $display("FAIL go_at_release busy got %b exp 001", status); end
    step(1);
    checks++; if ({res_hi, res_lo, status} !== {8'h00, 8'h03, 3'b010})
      begin errors++; $display("FAIL go_at_release res got %h %h %b exp 00 03 010", res_hi, res_lo, status); end
  endtask

  task automatic test_mul();
    int busy_bad = 0;
    run_op(8'd200, 8'd150, 2'b00);
    for (int i = 0; i < 8; i++) begin
      if (status !== 3'b001 || res_lo !== 8'h03 || res_hi !== 8'h00) busy_bad++;
      if (i < 7) step(1);
    end
    checks++; if (busy_bad != 0) begin errors++; $display("FAIL mul_busy bad_cycles %0d exp 0", busy_bad); end
    step(1);
    checks++; if ({res_hi, res_lo, status} !== {8'h75, 8'h30, 3'b010})
      begin errors++; $display("FAIL mul_200x150 got %h %h %b exp 75 30 010", res_hi, res_lo, status); end
  endtask

  task automatic test_div();
    run_op(8'd200, 8'd7, 2'b01); step(8);
    checks++; if ({res_hi, res_lo, status} !== {8'h04, 8'h1C, 3'b010})
      begin errors++; $display("FAIL div_200_7 got %h %h %b exp 04 1c 010", res_hi, res_lo, status); end
    run_op(8'd5, 8'd9, 2'b01); step(7);
    checks++; if (status !== 3'b001) begin errors++; $display("FAIL div_5_9 busy got %b exp 001", status); end
    step(1);
    checks++; if ({res_hi, res_lo, status} !== {8'h05, 8'h00, 3'b010})
      begin errors++; $display("FAIL div_5_9 got %h %h %b exp 05 00 010", res_hi, res_lo, status); end
  endtask

  task automatic test_single();
    run_op(8'hC8, 8'h00, 2'b01);
    checks++; if (status !== 3'b001) begin errors++; $display("FAIL div0 busy got %b exp 001", status); end
    step(1);
    checks++; if ({res_hi, res_lo, status} !== {8'hC8, 8'hFF, 3'b110})
      begin errors++; $display("FAIL div0 got %h %h %b exp c8 ff 110", res_hi, res_lo, status); end
    run_op(8'hF0, 8'h20, 2'b10); step(1);
    checks++; if ({res_hi, res_lo, status} !== {8'h01, 8'h10, 3'b010})
      begin errors++; $display("FAIL add_carry got %h %h %b exp 01 10 010", res_hi, res_lo, status); end
    run_op(8'h12, 8'h34, 2'b11); step(1);
    checks++; if ({res_hi, res_lo, status} !== {8'h00, 8'h00, 3'b110})
      begin errors++; $display("FAIL reserved got %h %h %b exp 00 00 110", res_hi, res_lo, status); end
  endtask

  task automatic test_go_hold();
    int rerun = 0;
    run_op(8'd3, 8'd5, 2'b00); step(8);
    checks++; if ({res_hi, res_lo, status} !== {8'h00, 8'h0F, 3'b010})
      begin errors++; $display("FAIL go_hold first got %h %h %b exp 00 0f 010", res_hi, res_lo, status); end
    for (int i = 0; i < 9; i++) begin
      step(1);
      if (status !== 3'b010) rerun++;
    end
    checks++; if (rerun != 0) begin errors++; $display("FAIL go_hold rerun cycles %0d exp 0", rerun); end
  endtask

  task automatic test_ignore_restart();
    run_op(8'd10, 8'd12, 2'b00);
    step(1); cmd = 8'h00; op_a = 8'hFF;
    step(1); cmd = 8'h80;
    step(6);
    checks++; if ({res_hi, res_lo, status} !== {8'h00, 8'h78, 3'b010})
      begin errors++; $display("FAIL ignore_in_run got %h %h %b exp 00 78 010", res_hi, res_lo, status); end
    step(2);
    checks++; if (status !== 3'b010) begin errors++; $display("FAIL ignore_no_restart got %b exp 010", status); end
    run_op(8'd6, 8'd7, 2'b10);
    checks++; if ({res_lo, status} !== {8'h78, 3'b001})
      begin errors++; $display("FAIL restart_e0 got %h %b exp 78 001", res_lo, status); end
    step(1);
    checks++; if ({res_hi, res_lo, status} !== {8'h00, 8'h0D, 3'b010})
      begin errors++; $display("FAIL restart_add got %h %h %b exp 00 0d 010", res_hi, res_lo, status); end
  endtask

  task automatic test_reset_mid();
    run_op(8'd200, 8'd150, 2'b00);
    step(3);
    checks++; if (status !== 3'b001) begin errors++; $display("FAIL mid_pre busy got %b exp 001", status); end
    reset = 1'b0; cmd = 8'h00;
    #1;
    checks++; if ({res_hi, res_lo, status} !== {8'h00, 8'h00, 3'b000})
      begin errors++; $display("FAIL mid_reset got %h %h %b exp 00 00 000", res_hi, res_lo, status); end
    step(2); reset = 1'b1;
    step(3);
    checks++; if ({res_hi, res_lo, status} !== {8'h00, 8'h00, 3'b000})
      begin errors++; $display("FAIL mid_after got %h %h %b exp 00 00 000", res_hi, res_lo, status); end
    run_op(8'hFF, 8'hFF, 2'b00); step(8);
    checks++; if ({res_hi, res_lo, status} !== {8'hFE, 8'h01, 3'b010})
      begin errors++; $display("FAIL mul_ffxff got %h %h %b exp fe 01 010", res_hi, res_lo, status); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_single();
    test_go_hold();
    test_ignore_restart();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
